// File: rtl/autoseller_multi_if.sv
// Insertion handshake and result bus between a coin front-end and autoseller_multi.
interface autoseller_multi_if #(
    parameter int unsigned MONEY_W = 6,
    parameter int unsigned TYPE_W  = 2
);
    localparam int unsigned NUM_TYPES = 2 ** TYPE_W;

    logic                 enable_i;
    logic [MONEY_W-1:0]   money_i;
    logic [TYPE_W-1:0]    drinktype_i;
    logic                 cancel_i;
    logic                 restock_i;
    logic                 ready_o;
    logic                 enable_o;
    logic [MONEY_W-1:0]   change_o;
    logic [TYPE_W-1:0]    drink_o;
    logic                 drink_valid_o;
    logic [NUM_TYPES-1:0] soldout_o;

    modport master (
        output enable_i, money_i, drinktype_i, cancel_i, restock_i,
        input  ready_o, enable_o, change_o, drink_o, drink_valid_o, soldout_o
    );

    modport slave (
        input  enable_i, money_i, drinktype_i, cancel_i, restock_i,
        output ready_o, enable_o, change_o, drink_o, drink_valid_o, soldout_o
    );
endinterface

// File: rtl/autoseller_multi.sv
// Multi-coin vending controller with credit, price table, cancel/refund and a one-cycle result strobe.
// Optional per-type stock tracking enabled by defining AUTOSELLER_STOCK_EN.
module autoseller_multi #(
    parameter int unsigned                      MONEY_W    = 6,
    parameter int unsigned                      TYPE_W     = 2,
    parameter logic [(2**TYPE_W)*MONEY_W-1:0]   PRICES     = {6'd25, 6'd20, 6'd15, 6'd10},
    parameter int unsigned                      STOCK_W    = 4,
    parameter int unsigned                      INIT_STOCK = 3
) (
    input  logic              clk,
    input  logic              reset,
    autoseller_multi_if.slave bus
);
    localparam int unsigned NUM_TYPES = 2 ** TYPE_W;
    localparam int unsigned SUM_W     = MONEY_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, OUT} state_t;

    state_t              state;
    logic [MONEY_W-1:0]  credit;
    logic [MONEY_W-1:0]  pend_change;
    logic [TYPE_W-1:0]   pend_drink;
    logic                pend_valid;

    logic                accept_c;
    logic                go_c;
    logic                empty_c;
    logic [SUM_W-1:0]    sum_c;
    logic [MONEY_W-1:0]  price_c;
    logic [MONEY_W-1:0]  cancel_amt_c;
    logic [MONEY_W-1:0]  credit_next_c;
    logic [MONEY_W-1:0]  pend_change_c;
    logic [TYPE_W-1:0]   pend_drink_c;
    logic                pend_valid_c;

`ifdef AUTOSELLER_STOCK_EN
    logic [STOCK_W-1:0]  stock [NUM_TYPES];
    assign empty_c = (stock[bus.drinktype_i] == '0);
`else
    logic unused_restock;
    assign unused_restock = bus.restock_i;
    assign empty_c        = 1'b0;
    assign bus.soldout_o  = '0;
`endif

    // Purchase decision for a strobe/cancel seen while accepting
    always_comb begin
        accept_c      = (state == IDLE) || (state == COLLECT);
        sum_c         = SUM_W'(credit) + SUM_W'(bus.money_i);
        price_c       = PRICES[32'(bus.drinktype_i) * MONEY_W +: MONEY_W];
        cancel_amt_c  = bus.enable_i ? sum_c[MONEY_W-1:0] : credit;
        go_c          = 1'b0;
        credit_next_c = credit;
        pend_change_c = '0;
        pend_drink_c  = '0;
        pend_valid_c  = 1'b0;
        if (accept_c) begin
            if (bus.enable_i && sum_c[MONEY_W]) begin
                // Overflowing insertion is bounced back; accumulated credit survives
                go_c          = 1'b1;
                pend_change_c = bus.money_i;
            end else if (bus.cancel_i) begin
                if (cancel_amt_c != '0) begin
                    go_c          = 1'b1;
                    pend_change_c = cancel_amt_c;
                    credit_next_c = '0;
                end
            end else if (bus.enable_i) begin
                if (sum_c >= SUM_W'(price_c)) begin
                    go_c          = 1'b1;
                    credit_next_c = '0;
                    if (empty_c) begin
                        pend_change_c = sum_c[MONEY_W-1:0];
                    end else begin
                        pend_change_c = sum_c[MONEY_W-1:0] - price_c;
                        pend_drink_c  = bus.drinktype_i;
                        pend_valid_c  = 1'b1;
                    end
                end else begin
                    credit_next_c = sum_c[MONEY_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            credit            <= '0;
            pend_change       <= '0;
            pend_drink        <= '0;
            pend_valid        <= 1'b0;
            bus.ready_o       <= 1'b1;
            bus.enable_o      <= 1'b0;
            bus.change_o      <= '0;
            bus.drink_o       <= '0;
            bus.drink_valid_o <= 1'b0;
`ifdef AUTOSELLER_STOCK_EN
            for (int i = 0; i < int'(NUM_TYPES); i++) stock[i] <= STOCK_W'(INIT_STOCK);
            bus.soldout_o     <= {NUM_TYPES{INIT_STOCK == 0}};
`endif
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    credit <= credit_next_c;
                    if (go_c) begin
                        state       <= VEND;
                        bus.ready_o <= 1'b0;
                        pend_change <= pend_change_c;
                        pend_drink  <= pend_drink_c;
                        pend_valid  <= pend_valid_c;
                    end else begin
                        state <= (credit_next_c != '0) ? COLLECT : IDLE;
                    end
`ifdef AUTOSELLER_STOCK_EN
                    if (state == IDLE && bus.restock_i) begin
                        for (int i = 0; i < int'(NUM_TYPES); i++) stock[i] <= STOCK_W'(INIT_STOCK);
                        bus.soldout_o <= {NUM_TYPES{INIT_STOCK == 0}};
                    end
`endif
                end
                VEND: begin
                    state             <= OUT;
                    bus.enable_o      <= 1'b1;
                    bus.change_o      <= pend_change;
                    bus.drink_o       <= pend_drink;
                    bus.drink_valid_o <= pend_valid;
`ifdef AUTOSELLER_STOCK_EN
                    // Stock and sold-out flag change together with the result strobe
                    if (pend_valid && stock[pend_drink] != '0) begin
                        stock[pend_drink]         <= stock[pend_drink] - STOCK_W'(1);
                        bus.soldout_o[pend_drink] <= (stock[pend_drink] == STOCK_W'(1));
                    end
`endif
                end
                OUT: begin
                    state             <= (credit != '0) ? COLLECT : IDLE;
                    bus.ready_o       <= 1'b1;
                    bus.enable_o      <= 1'b0;
                    bus.change_o      <= '0;
                    bus.drink_o       <= '0;
                    bus.drink_valid_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_autoseller_multi.sv
// Directed self-checking bench for autoseller_multi; stock checks adapt to AUTOSELLER_STOCK_EN.
module tb_autoseller_multi;
    localparam int unsigned MONEY_W = 6;
    localparam int unsigned TYPE_W  = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    autoseller_multi_if #(.MONEY_W(MONEY_W), .TYPE_W(TYPE_W)) bus ();

    // Type 3 priced at the top of the money range to reach overflow with credit held
    autoseller_multi #(
        .MONEY_W(MONEY_W), .TYPE_W(TYPE_W),
        .PRICES({6'd63, 6'd20, 6'd15, 6'd10}),
        .STOCK_W(4), .INIT_STOCK(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

`ifdef AUTOSELLER_STOCK_EN
    localparam bit STOCK = 1'b1;
`else
    localparam bit STOCK = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic en, input logic [5:0] m, input logic [1:0] t, input logic c);
        bus.enable_i = en; bus.money_i = m; bus.drinktype_i = t; bus.cancel_i = c;
        tick();
        bus.enable_i = 1'b0; bus.money_i = '0; bus.cancel_i = 1'b0;
    endtask

    task automatic no_result(input string tag);
        check({tag, ":ready"}, 32'(bus.ready_o), 1);
        check({tag, ":enable"}, 32'(bus.enable_o), 0);
    endtask

    // Called right after the accepting edge: VEND, then OUT strobe, then back to accepting
    task automatic result(input string tag, input int chg, input int drk, input int vld);
        check({tag, ":vend_ready"}, 32'(bus.ready_o), 0);
        check({tag, ":vend_enable"}, 32'(bus.enable_o), 0);
        tick();
        check({tag, ":enable"}, 32'(bus.enable_o), 1);
        check({tag, ":change"}, 32'(bus.change_o), 32'(chg));
        check({tag, ":drink"}, 32'(bus.drink_o), 32'(drk));
        check({tag, ":valid"}, 32'(bus.drink_valid_o), 32'(vld));
        tick();
        check({tag, ":post_enable"}, 32'(bus.enable_o), 0);
        check({tag, ":post_ready"}, 32'(bus.ready_o), 1);
        check({tag, ":post_change"}, 32'(bus.change_o), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":ready"}, 32'(bus.ready_o), 1);
        check({tag, ":enable"}, 32'(bus.enable_o), 0);
        check({tag, ":change"}, 32'(bus.change_o), 0);
        check({tag, ":drink"}, 32'(bus.drink_o), 0);
        check({tag, ":valid"}, 32'(bus.drink_valid_o), 0);
        check({tag, ":soldout"}, 32'(bus.soldout_o), 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.enable_i = 1'b0; bus.money_i = '0; bus.drinktype_i = '0;
        bus.cancel_i = 1'b0; bus.restock_i = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        apply(1, 20, 1, 0);
        result("buy20_t1", 5, 1, 1);

        apply(1, 5, 2, 0); no_result("t2_5a");
        apply(1, 5, 2, 0); no_result("t2_5b");
        apply(1, 5, 2, 0); no_result("t2_5c");
        apply(1, 10, 2, 0);
        result("t2_finish", 5, 2, 1);

        apply(1, 5, 3, 0); no_result("cancel_5");
        apply(1, 10, 3, 0); no_result("cancel_10");
        apply(0, 0, 3, 1);
        result("cancel15", 15, 0, 0);
        apply(0, 0, 0, 1); no_result("cancel_idle");

        // Cancel with a same-cycle strobe that would otherwise buy type 0
        apply(1, 12, 0, 1);
        result("cancel_wins", 12, 0, 0);

        for (int i = 0; i < 3; i++) begin
            apply(1, 10, 0, 0);
            result("buy_t0", 0, 0, 1);
        end
        check("soldout_after3", 32'(bus.soldout_o), STOCK ? 1 : 0);
        apply(1, 10, 0, 0);
        result("buy_t0_4th", STOCK ? 10 : 0, 0, STOCK ? 0 : 1);
        bus.restock_i = 1'b1;
        tick();
        bus.restock_i = 1'b0;
        check("soldout_restock", 32'(bus.soldout_o), 0);
        no_result("restock");

        apply(1, 30, 3, 0); no_result("ovf_30a");
        apply(1, 30, 3, 0); no_result("ovf_30b");
        apply(1, 10, 3, 0);
        result("ovf_refund", 10, 0, 0);
        apply(0, 0, 3, 1);
        result("ovf_cancel60", 60, 0, 0);
        apply(1, 30, 3, 0); no_result("exact_30a");
        apply(1, 30, 3, 0); no_result("exact_30b");
        apply(1, 3, 3, 0);
        result("exact63", 0, 3, 1);

        // Strobe held through VEND must not be queued
        bus.enable_i = 1'b1; bus.money_i = 20; bus.drinktype_i = 1;
        tick();
        tick();
        check("hold_enable", 32'(bus.enable_o), 1);
        check("hold_change", 32'(bus.change_o), 5);
        bus.enable_i = 1'b0; bus.money_i = '0;
        tick();
        no_result("hold_back");
        tick();
        no_result("hold_noqueue");

        // Drop type 0 stock to 2, then reset mid-VEND must reload it
        apply(1, 10, 0, 0);
        result("pre_reset_buy", 0, 0, 1);
        apply(1, 20, 1, 0);
        check("rst_vend_ready", 32'(bus.ready_o), 0);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        reset = 1'b1;
        tick();
        no_result("rst_after1");
        tick();
        no_result("rst_after2");
        for (int i = 0; i < 3; i++) begin
            apply(1, 10, 0, 0);
            result("post_rst_t0", 0, 0, 1);
        end
        check("post_rst_soldout", 32'(bus.soldout_o), STOCK ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/autoseller_multi.md
# autoseller_multi

Parametrised multi-coin vending controller, next generation of the single-shot autoseller. Accumulates credit over several insertions, prices each drink type from a parameter table, tracks per-type stock, and supports cancel/refund. It keeps the enable_i/ready_o input handshake and the one-cycle enable_o result strobe, so existing benches drive it unchanged.

## Interface
- MONEY_W, 6: width of money_i, credit register and change_o
- TYPE_W, 2: width of drinktype_i/drink_o; NUM_TYPES = 2**TYPE_W
- PRICES, {6'd25,6'd20,6'd15,6'd10}: packed NUM_TYPES*MONEY_W price table, type 0 in LSBs
- STOCK_W, 4: per-type stock counter width
- INIT_STOCK, 3: stock loaded at reset and on restock
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable_i  input  1  insertion strobe, accepted only when ready_o=1
- money_i  input  MONEY_W  amount inserted with this strobe (0 legal)
- drinktype_i  input  TYPE_W  selected drink, latched on every accepted strobe (last wins)
- cancel_i  input  1  refund request, accepted only when ready_o=1
- restock_i  input  1  reload all stock counters, honoured only in IDLE
- ready_o  output  1  block accepts enable_i/cancel_i
- enable_o  output  1  one-cycle result strobe
- change_o  output  MONEY_W  change/refund, valid with enable_o, else 0
- drink_o  output  TYPE_W  dispensed type, valid with enable_o, else 0
- drink_valid_o  output  1  1 = drink dispensed, 0 = refund only; 0 when enable_o=0
- soldout_o  output  NUM_TYPES  bit i = stock of type i is 0

## Operation
- States: IDLE (credit=0), COLLECT (credit>0), VEND, OUT. ready_o=1 in IDLE/COLLECT, 0 in VEND/OUT.
- Accepted strobe: sum = credit + money_i computed MONEY_W+1 bits wide.
  - sum > 2**MONEY_W-1: overflow, insertion rejected. Credit unchanged, result = refund of money_i (drink_valid_o=0). Afterwards return to COLLECT/IDLE per credit.
  - else if sum >= PRICES[type]: type stock 0 -> refund sum, drink_valid_o=0, credit cleared. Otherwise dispense: change = sum - price, drink_o=type, drink_valid_o=1, stock[type] decrements, credit cleared.
  - else credit = sum; COLLECT if sum>0, else IDLE; no result, ready_o stays 1.
- cancel_i with ready_o=1: refund credit (+ money_i if enable_i same cycle; cancel wins over purchase, overflow rule still applies to the sum). cancel_i in IDLE with no money: no result.
- Price 0 dispenses on any strobe with change = sum.
- Any result path: -> VEND -> OUT (enable_o=1) -> IDLE, or COLLECT if an overflow refund left credit.
- restock_i in IDLE: all counters = INIT_STOCK next edge; ignored elsewhere.
- Stock counters never wrap below 0.

## Timing
- Reset (async, active-low): state IDLE, credit 0, stock INIT_STOCK; ready_o=1, enable_o=0, change_o=0, drink_o=0, drink_valid_o=0, soldout_o = 0 (all 1 if INIT_STOCK=0).
- Strobe sampled at edge N -> ready_o=0 after N, enable_o high exactly one cycle after edge N+1, ready_o=1 after edge N+2.
- enable_i/cancel_i while ready_o=0: ignored, not queued.
- Stock decrement and soldout_o update visible in the OUT cycle.
- Reset mid-VEND/OUT: pending result and credit discarded, no enable_o pulse.
- All outputs registered.

## Configuration
- AUTOSELLER_STOCK_EN defined: stock counters, sold-out refunds, soldout_o and restock_i as above.
- Undefined: no counters, stock unlimited, soldout_o tied 0, restock_i ignored, sold-out refund path absent.

## Test plan
- Defaults; insert 20, type 1 -> enable_o two edges later, change 5, drink 01, drink_valid_o 1.
- Insert 5,5,5 type 2 -> ready_o stays 1, no enable_o; insert 10 -> change 5, drink 10, valid 1.
- Insert 5 then 10, then cancel_i -> change 15, drink_valid_o 0, back to IDLE.
- AUTOSELLER_STOCK_EN, INIT_STOCK=3: buy type 0 three times with 10 -> soldout_o[0]=1; fourth insert 10 -> refund 10, valid 0; restock_i in IDLE -> soldout_o[0]=0.
- Credit 60 via 30+30 type 3, insert 10 -> refund 10, valid 0, ready_o back 1 with credit 60; cancel -> change 60.
- Assert reset during VEND -> no enable_o, all outputs reset values, ready_o=1, stock = INIT_STOCK.
